axi4l_reg_bank: RTL

//  AXI4-Lite slave register bank that terminates the master port of WB2AXI4LITE_BRIDGE.

---
 rtl/axi4l_reg_bank.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/axi4l_reg_bank.sv
// AXI4-Lite slave register bank: NUM_REGS byte-strobed R/W registers, exported to core logic.
// Latency: write commits one cycle after both AW and W are taken (BVALID, REG_WE and REG_Q update together); read data registered at the AR edge.
// Backpressure: one outstanding write and one outstanding read; AWREADY/WREADY/ARREADY stay low until the pending response is accepted.
//
// Ports:
//   CLK, RSTN                 clock (rising edge), asynchronous active-low reset
//   AW*/W*/B*                 AXI4-Lite write address, write data and write response channels
//   AR*/R*                    AXI4-Lite read address and read data channels
//   REG_Q                     all register contents, reg i at [i*DATA_WIDTH +: DATA_WIDTH]
//   REG_WE                    one-cycle pulse on bit i when reg i is written (also with WSTRB=0)
module axi4l_reg_bank #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 16
) (
  input  logic                           CLK,
  input  logic                           RSTN,
  input  logic [ADDR_WIDTH-1:0]          AWADDR,
  input  logic                           AWVALID,
  output logic                           AWREADY,
  input  logic [DATA_WIDTH-1:0]          WDATA,
  input  logic [DATA_WIDTH/8-1:0]        WSTRB,
  input  logic                           WVALID,
  output logic                           WREADY,
  output logic [1:0]                     BRESP,
  output logic                           BVALID,
  input  logic                           BREADY,
  input  logic [ADDR_WIDTH-1:0]          ARADDR,
  input  logic                           ARVALID,
  output logic                           ARREADY,
  output logic [DATA_WIDTH-1:0]          RDATA,
  output logic [1:0]                     RRESP,
  output logic                           RVALID,
  input  logic                           RREADY,
  output logic [NUM_REGS*DATA_WIDTH-1:0] REG_Q,
  output logic [NUM_REGS-1:0]            REG_WE
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int BO     = $clog2(STRB_W);
  localparam int IW     = $clog2(NUM_REGS);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {W_IDLE, W_HAVE_AW, W_HAVE_W, W_COMMIT, W_RESP} wstate_t;
  typedef enum logic {R_IDLE, R_RESP} rstate_t;

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];

  wstate_t               wstate;
  logic                  aw_rdy;
  logic                  w_rdy;
  logic                  b_vld;
  logic [1:0]            b_resp;
  logic [IW-1:0]         w_idx;
  logic                  w_ok;
  logic [DATA_WIDTH-1:0] w_dat;
  logic [STRB_W-1:0]     w_strb;
  logic [NUM_REGS-1:0]   reg_we;

  rstate_t               rstate;
  logic                  ar_rdy;
  logic                  r_vld;
  logic [1:0]            r_resp;
  logic [DATA_WIDTH-1:0] r_dat;

  logic aw_hs;
  logic w_hs;
  logic ar_hs;
  logic aw_ok;
  logic ar_ok;

  // Word address (byte offset dropped) must be below NUM_REGS; this single
  // compare covers both nonzero upper bits and an index past the last reg.
  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
    return (a >> BO) < ADDR_WIDTH'(NUM_REGS);
  endfunction

  assign aw_hs = AWVALID & aw_rdy;
  assign w_hs  = WVALID & w_rdy;
  assign ar_hs = ARVALID & ar_rdy;
  assign aw_ok = in_range(AWADDR);
  assign ar_ok = in_range(ARADDR);

  // Write channel FSM and register storage
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      wstate <= W_IDLE;
      aw_rdy <= 1'b0;
      w_rdy  <= 1'b0;
      b_vld  <= 1'b0;
      b_resp <= RESP_OKAY;
      w_idx  <= '0;
      w_ok   <= 1'b0;
      w_dat  <= '0;
      w_strb <= '0;
      reg_we <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      reg_we <= '0;
      case (wstate)
        W_IDLE: begin
          if (aw_hs) begin
            w_idx <= AWADDR[BO +: IW];
            w_ok  <= aw_ok;
          end
          if (w_hs) begin
            w_dat  <= WDATA;
            w_strb <= WSTRB;
          end
          if (aw_hs && w_hs) begin
            aw_rdy <= 1'b0;
            w_rdy  <= 1'b0;
            wstate <= W_COMMIT;
          end else if (aw_hs) begin
            aw_rdy <= 1'b0;
            w_rdy  <= 1'b1;
            wstate <= W_HAVE_AW;
          end else if (w_hs) begin
            aw_rdy <= 1'b1;
            w_rdy  <= 1'b0;
            wstate <= W_HAVE_W;
          end else begin
            // Also the path that raises the READYs on the first edge after reset
            aw_rdy <= 1'b1;
            w_rdy  <= 1'b1;
          end
        end
        W_HAVE_AW: begin
          if (w_hs) begin
            w_dat  <= WDATA;
            w_strb <= WSTRB;
            w_rdy  <= 1'b0;
            wstate <= W_COMMIT;
          end
        end
        W_HAVE_W: begin
          if (aw_hs) begin
            w_idx  <= AWADDR[BO +: IW];
            w_ok   <= aw_ok;
            aw_rdy <= 1'b0;
            wstate <= W_COMMIT;
          end
        end
        W_COMMIT: begin
          if (w_ok) begin
            for (int b = 0; b < STRB_W; b++) begin
              if (w_strb[b]) regs[w_idx][b*8 +: 8] <= w_dat[b*8 +: 8];
            end
            reg_we[w_idx] <= 1'b1;
          end
          b_resp <= w_ok ? RESP_OKAY : RESP_SLVERR;
          b_vld  <= 1'b1;
          wstate <= W_RESP;
        end
        W_RESP: begin
          if (BREADY) begin
            b_vld  <= 1'b0;
            aw_rdy <= 1'b1;
            w_rdy  <= 1'b1;
            wstate <= W_IDLE;
          end
        end
        default: wstate <= W_IDLE;
      endcase
    end
  end

  // Read channel FSM. Data is captured from the flops at the AR edge, so a
  // commit on the same edge is not yet visible and the old value is returned.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      rstate <= R_IDLE;
      ar_rdy <= 1'b0;
      r_vld  <= 1'b0;
      r_resp <= RESP_OKAY;
      r_dat  <= '0;
    end else begin
      case (rstate)
        R_IDLE: begin
          if (ar_hs) begin
            r_dat  <= ar_ok ? regs[ARADDR[BO +: IW]] : '0;
            r_resp <= ar_ok ? RESP_OKAY : RESP_SLVERR;
            r_vld  <= 1'b1;
            ar_rdy <= 1'b0;
            rstate <= R_RESP;
          end else begin
            ar_rdy <= 1'b1;
          end
        end
        R_RESP: begin
          if (RREADY) begin
            r_vld  <= 1'b0;
            ar_rdy <= 1'b1;
            rstate <= R_IDLE;
          end
        end
        default: rstate <= R_IDLE;
      endcase
    end
  end

  assign AWREADY = aw_rdy;
  assign WREADY  = w_rdy;
  assign BVALID  = b_vld;
  assign BRESP   = b_resp;
  assign ARREADY = ar_rdy;
  assign RVALID  = r_vld;
  assign RRESP   = r_resp;
  assign RDATA   = r_dat;
  assign REG_WE  = reg_we;

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg_q
    assign REG_Q[i*DATA_WIDTH +: DATA_WIDTH] = regs[i];
  end

endmodule
